// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-I/O SPI NOR read engine (mode 0, READ 0x03), one valid strobe per byte.
// Optional build macro SPI_WAKEUP_EN: send 0xAB after reset and wait WAKE_WAIT cycles before IDLE.
module spi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 4,
  parameter int WAKE_WAIT = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] sr_addr,
  input  logic [15:0] sr_len,
  input  logic        sr_go,
  output logic        sr_rdy,
  output logic [7:0]  sr_data,
  output logic        sr_valid,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WT_MAX = (WAKE_WAIT > CS_GAP) ? WAKE_WAIT : CS_GAP;
  localparam int WT_W   = $clog2(WT_MAX + 1);

`ifdef SPI_WAKEUP_EN
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP, S_WAKE, S_WWAIT} state_t;
  localparam state_t S_RST = S_WAKE;
`else
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;
  localparam state_t S_RST = S_GAP;
`endif

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [WT_W-1:0]  wt_cnt;
  logic [4:0]       bit_cnt;
  logic [15:0]      byte_cnt;
  logic [15:0]      len_q;
  logic [31:0]      tx_sh;
  logic [7:0]       rx_sh;
  logic             sclk_q, cs_n_q, byte_pend, sr_valid_q;
  logic [7:0]       sr_data_q;
  logic             wake_hold, shifting, div_end, rise, fall;

  // States in which chip select is held low.
  function automatic logic is_active(input state_t s);
    case (s)
      S_CMD, S_ADDR, S_DATA: is_active = 1'b1;
`ifdef SPI_WAKEUP_EN
      S_WAKE:                is_active = 1'b1;
`endif
      default:               is_active = 1'b0;
    endcase
  endfunction

`ifdef SPI_WAKEUP_EN
  logic wake_arm;
  // First WAKE cycle only loads 0xAB and drops cs_n; clocking starts after.
  assign wake_hold = (state == S_WAKE) && !wake_arm;
`else
  assign wake_hold = 1'b0;
`endif

  assign shifting = is_active(state) && !wake_hold;
  assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise     = shifting && div_end && !sclk_q;
  assign fall     = shifting && div_end && sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sr_go) state_nxt = S_CMD;
      S_CMD:   if (fall && bit_cnt == 5'd7) state_nxt = S_ADDR;
      S_ADDR:  if (fall && bit_cnt == 5'd23) state_nxt = S_DATA;
      S_DATA:  if (fall && bit_cnt[2:0] == 3'd7 && byte_cnt == len_q) state_nxt = S_GAP;
      S_GAP:   if (wt_cnt == WT_W'(CS_GAP - 1)) state_nxt = S_IDLE;
`ifdef SPI_WAKEUP_EN
      S_WAKE:  if (fall && bit_cnt == 5'd7) state_nxt = S_WWAIT;
      S_WWAIT: if (wt_cnt == WT_W'(WAKE_WAIT - 1)) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      wt_cnt     <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      tx_sh      <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      byte_pend  <= 1'b0;
      sr_valid_q <= 1'b0;
      sr_data_q  <= '0;
`ifdef SPI_WAKEUP_EN
      wake_arm   <= 1'b0;
`endif
    end else begin
      // Low on entry together with the first mosi bit, high one cycle after the last fall.
      cs_n_q     <= !(is_active(state) || is_active(state_nxt));
      byte_pend  <= rise && (state == S_DATA) && (bit_cnt[2:0] == 3'd7);
      sr_valid_q <= byte_pend;
      if (byte_pend) sr_data_q <= rx_sh;

      if (!shifting || div_end) div_cnt <= '0;
      else                      div_cnt <= div_cnt + 1'b1;

      if (rise)      sclk_q <= 1'b1;
      else if (fall) sclk_q <= 1'b0;

      if (state == S_IDLE) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (fall) begin
        bit_cnt <= (state_nxt != state) ? 5'd0 : bit_cnt + 1'b1;
        if (state == S_DATA && bit_cnt[2:0] == 3'd7) byte_cnt <= byte_cnt + 1'b1;
      end

      // Shifting zeros in leaves mosi low for the whole data phase.
      if (state == S_IDLE && sr_go) tx_sh <= {8'h03, sr_addr};
      else if (fall)                tx_sh <= {tx_sh[30:0], 1'b0};

      if (state_nxt != state) wt_cnt <= '0;
`ifdef SPI_WAKEUP_EN
      else if (state == S_GAP || state == S_WWAIT) wt_cnt <= wt_cnt + 1'b1;
      if (wake_hold) begin
        tx_sh    <= {8'hAB, 24'h0};
        wake_arm <= 1'b1;
      end
`else
      else if (state == S_GAP) wt_cnt <= wt_cnt + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rise) rx_sh <= {rx_sh[6:0], spi_miso};
    if (state == S_IDLE && sr_go) len_q <= sr_len;
  end

  assign sr_rdy   = (state == S_IDLE);
  assign sr_data  = sr_data_q;
  assign sr_valid = sr_valid_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = tx_sh[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural mode-0 SPI flash model.
module tb_spi_flash_reader;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] sr_addr = '0;
  logic [15:0] sr_len = '0;
  logic        sr_go = 1'b0;
  logic        sr_rdy, sr_valid, spi_sclk, spi_cs_n, spi_mosi;
  logic [7:0]  sr_data;
  logic        spi_miso = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .WAKE_WAIT(512)) dut (
    .clk(clk), .rst_n(rst_n), .sr_addr(sr_addr), .sr_len(sr_len), .sr_go(sr_go),
    .sr_rdy(sr_rdy), .sr_data(sr_data), .sr_valid(sr_valid), .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Flash model and bus monitor, evaluated on the falling clk edge.
  int          cyc = 0, rise_cnt = 0, mosi_ones = 0, vcnt = 0;
  int          last_rise_cyc = 0, last_fall_cyc = 0, cs_rise_cyc = 0, rdy_rise_cyc = 0;
  logic [31:0] cmd_word = '0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_rdy = 1'b0;
  logic [7:0]  vdata [256];
  int          vcyc [256];
  logic        fixed_mode = 1'b1;
  logic [7:0]  fixed_val = 8'hA5;

  always @(negedge clk) begin
    int d;
    logic [7:0] b;
    cyc = cyc + 1;
    if (prev_cs && !spi_cs_n) begin
      rise_cnt = 0;
      cmd_word = '0;
      mosi_ones = 0;
    end
    if (!prev_cs && spi_cs_n) cs_rise_cyc = cyc;
    if (!spi_cs_n && !prev_sclk && spi_sclk) begin
      if (rise_cnt < 32) cmd_word = {cmd_word[30:0], spi_mosi};
      else if (spi_mosi) mosi_ones = mosi_ones + 1;
      rise_cnt = rise_cnt + 1;
      last_rise_cyc = cyc;
    end
    if (prev_sclk && !spi_sclk) begin
      last_fall_cyc = cyc;
      if (!spi_cs_n && rise_cnt >= 32) begin
        d = rise_cnt - 32;
        b = fixed_mode ? fixed_val : (cmd_word[7:0] + 8'(d / 8));
        spi_miso = b[7 - (d % 8)];
      end
    end
    if (sr_valid) begin
      vdata[vcnt % 256] = sr_data;
      vcyc[vcnt % 256] = cyc;
      vcnt = vcnt + 1;
    end
    if (!prev_rdy && sr_rdy) rdy_rise_cyc = cyc;
    prev_sclk = spi_sclk;
    prev_cs = spi_cs_n;
    prev_rdy = sr_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] a, input logic [15:0] l);
    sr_addr = a;
    sr_len = l;
    sr_go = 1'b1;
    tick();
    sr_go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (sr_rdy !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(sr_rdy), 32'd1);
    tick();
  endtask

  initial begin
    int v0, bad, gaps;

    // Reset state
    repeat (3) tick();
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_valid", 32'(sr_valid), 32'd0);
    check("rst_rdy", 32'(sr_rdy), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_data", 32'(sr_data), 32'd0);
    rst_n = 1'b1;
    repeat (CS_GAP - 1) tick();
    check("rdy_early", 32'(sr_rdy), 32'd0);
    tick();
    check("rdy_after_gap", 32'(sr_rdy), 32'd1);

    // Single byte read
    fixed_mode = 1'b1;
    fixed_val = 8'hA5;
    v0 = vcnt;
    start(24'h040000, 16'h0000);
    check("go_rdy_drop", 32'(sr_rdy), 32'd0);
    check("go_cs_low", 32'(spi_cs_n), 32'd0);
    wait_idle("single_done", 400);
    check("single_cmd", cmd_word, 32'h03040000);
    check("single_sclk_pulses", 32'(rise_cnt), 32'd40);
    check("single_nvalid", 32'(vcnt - v0), 32'd1);
    check("single_data", 32'(vdata[v0 % 256]), 32'hA5);
    check("single_data_hold", 32'(sr_data), 32'hA5);
    check("single_valid_lat", 32'(vcyc[v0 % 256] - last_rise_cyc), 32'd1);
    check("single_cs_after_fall", 32'(cs_rise_cyc - last_fall_cyc), 32'd1);
    check("single_rdy_gap", 32'(rdy_rise_cyc - last_fall_cyc), 32'(CS_GAP));

    // Row read with a busy-time sr_go that must be ignored
    fixed_mode = 1'b0;
    v0 = vcnt;
    start(24'h041080, 16'h007f);
    repeat (300) tick();
    sr_addr = 24'h123456;
    sr_go = 1'b1;
    tick();
    check("busy_rdy", 32'(sr_rdy), 32'd0);
    sr_go = 1'b0;
    wait_idle("row_done", 6000);
    check("row_nvalid", 32'(vcnt - v0), 32'd128);
    check("row_first", 32'(vdata[v0 % 256]), 32'h80);
    check("row_last", 32'(vdata[(v0 + 127) % 256]), 32'hFF);
    bad = 0;
    gaps = 0;
    for (int i = 0; i < 128; i++) begin
      if (vdata[(v0 + i) % 256] !== 8'(8'h80 + i)) bad++;
      if (i > 0 && vcyc[(v0 + i) % 256] - vcyc[(v0 + i - 1) % 256] != 16 * CLK_DIV) gaps++;
    end
    check("row_data_bad", 32'(bad), 32'd0);
    check("row_spacing_bad", 32'(gaps), 32'd0);
    check("row_cmd", cmd_word, 32'h03041080);
    check("row_sclk_pulses", 32'(rise_cnt), 32'd1056);
    check("row_mosi_data_low", 32'(mosi_ones), 32'd0);
    repeat (10) tick();
    check("busy_no_restart_cs", 32'(spi_cs_n), 32'd1);
    check("busy_no_restart_rdy", 32'(sr_rdy), 32'd1);

    // Abort by reset during the address phase, then a fresh read
    fixed_mode = 1'b1;
    fixed_val = 8'h3C;
    start(24'h0A0B0C, 16'h0003);
    repeat (60) tick();
    check("abort_in_xfer", 32'(spi_cs_n), 32'd0);
    v0 = vcnt;
    rst_n = 1'b0;
    #1;
    check("abort_cs_high", 32'(spi_cs_n), 32'd1);
    check("abort_sclk_low", 32'(spi_sclk), 32'd0);
    repeat (3) tick();
    check("abort_no_valid", 32'(vcnt - v0), 32'd0);
    check("abort_rdy_low", 32'(sr_rdy), 32'd0);
    rst_n = 1'b1;
    wait_idle("abort_recover", 20);
    v0 = vcnt;
    start(24'h000010, 16'h0000);
    wait_idle("fresh_done", 400);
    check("fresh_cmd", cmd_word, 32'h03000010);
    check("fresh_nvalid", 32'(vcnt - v0), 32'd1);
    check("fresh_data", 32'(vdata[v0 % 256]), 32'h3C);
    check("fresh_sclk_pulses", 32'(rise_cnt), 32'd40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
